// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_n family.
package stream_mux_pkg;

   localparam int MUX_MODE_FIXED = 0;
   localparam int MUX_MODE_RR    = 1;

   // Channel-index width, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from a pointer with wrap-around and
// moves the pointer past the winner when i_adv is asserted.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int N_CH  = 2,
   localparam int SEL_W = idx_width(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] i_req,
   input  logic            i_adv,
   output logic [N_CH-1:0] o_grant
);

   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_next_ptr;
   logic             w_found;
   int               w_idx;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      o_grant    = '0;
      w_next_ptr = r_ptr;
      w_found    = 1'b0;
      w_idx      = 0;
      for (int k = 0; k < N_CH; k++) begin
         w_idx = (int'(r_ptr) + k) % N_CH;
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_grant[w_idx] = 1'b1;
            w_next_ptr     = SEL_W'((w_idx + 1) % N_CH);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst)        r_ptr <= '0;
      else if (i_adv) r_ptr <= w_next_ptr;
   end

endmodule

// File: rtl/stream_mux_n.sv
// N-to-1 valid/ready stream mux with one registered output stage.
// Optional packet lock is enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_n
   import stream_mux_pkg::*;
#(
   parameter  int N_CH  = 2,
   parameter  int WIDTH = 8,
   parameter  int MODE  = MUX_MODE_FIXED,
   localparam int SEL_W = idx_width(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_last
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_ch;
   logic             r_out_last;

   logic             w_load;
   logic             w_xfer;
   logic             w_xfer_last;
   logic [N_CH-1:0]  w_grant;
   logic [SEL_W-1:0] w_gnt_idx;
   logic [WIDTH-1:0] w_gnt_data;
   logic             w_locked;
   logic [N_CH-1:0]  w_lock_mask;

   assign w_load   = ~r_out_valid | out_ready;
   assign in_ready = (rst || !w_load) ? '0 : w_grant;
   assign w_xfer   = |(in_valid & in_ready);

   always_comb begin
      w_gnt_idx   = '0;
      w_gnt_data  = '0;
      w_xfer_last = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_grant[i]) begin
            w_gnt_idx   = SEL_W'(i);
            w_gnt_data  = in_data[i*WIDTH +: WIDTH];
            w_xfer_last = in_last[i];
         end
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   logic             r_locked;
   logic [SEL_W-1:0] r_lock_ch;

   // A non-last beat pins the grant to its channel until the last beat moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_locked  <= 1'b0;
         r_lock_ch <= '0;
      end else if (w_xfer) begin
         r_locked  <= ~w_xfer_last;
         r_lock_ch <= w_gnt_idx;
      end
   end

   assign w_locked = r_locked;
   always_comb begin
      w_lock_mask = '0;
      for (int i = 0; i < N_CH; i++) w_lock_mask[i] = (r_lock_ch == SEL_W'(i));
   end
`else
   assign w_locked    = 1'b0;
   assign w_lock_mask = '0;
`endif

   if (MODE == MUX_MODE_RR) begin : g_rr
      logic [N_CH-1:0] w_req;
      logic            w_adv;

      assign w_req = w_locked ? (in_valid & w_lock_mask) : in_valid;
`ifdef STREAM_MUX_LOCK_EN
      assign w_adv = w_xfer & w_xfer_last;
`else
      assign w_adv = w_xfer;
`endif

      rr_arbiter #(.N_CH(N_CH)) u_arb (
         .clk     (clk),
         .rst     (rst),
         .i_req   (w_req),
         .i_adv   (w_adv),
         .o_grant (w_grant)
      );
   end else begin : g_fixed
      logic [N_CH-1:0] w_sel_hot;

      // Out-of-range sel matches no channel, so it yields no grant.
      always_comb begin
         w_sel_hot = '0;
         for (int i = 0; i < N_CH; i++) w_sel_hot[i] = (sel == SEL_W'(i));
      end

      assign w_grant = (w_locked ? w_lock_mask : w_sel_hot) & in_valid;
   end

   // NOTE: data/channel registers are reset as well, since a cleared output is observable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= w_xfer;
         if (w_xfer) begin
            r_out_data <= w_gnt_data;
            r_out_ch   <= w_gnt_idx;
            r_out_last <= w_xfer_last;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: three instances (fixed 4ch, fixed 3ch, round-robin 4ch)
// checked against a per-cycle behavioural model; honours STREAM_MUX_LOCK_EN.
module tb_stream_mux_n;

`ifdef STREAM_MUX_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]  vld  [3];
   logic [31:0] dat  [3];
   logic [3:0]  lst  [3];
   logic [1:0]  sel  [3];
   logic        ordy [3];

   wire  [3:0]  rdy  [3];
   wire  [2:0]  rdy3;
   wire         ov   [3];
   wire  [7:0]  od   [3];
   wire  [1:0]  och  [3];
   wire         ol   [3];

   assign rdy[1] = {1'b0, rdy3};

   stream_mux_n #(.N_CH(4), .WIDTH(8), .MODE(0)) u_fix4 (
      .clk(clk), .rst(rst), .sel(sel[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .in_data(dat[0]), .in_last(lst[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_data(od[0]), .out_ch(och[0]), .out_last(ol[0]));

   stream_mux_n #(.N_CH(3), .WIDTH(8), .MODE(0)) u_fix3 (
      .clk(clk), .rst(rst), .sel(sel[1]), .in_valid(vld[1][2:0]), .in_ready(rdy3),
      .in_data(dat[1][23:0]), .in_last(lst[1][2:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_data(od[1]), .out_ch(och[1]), .out_last(ol[1]));

   stream_mux_n #(.N_CH(4), .WIDTH(8), .MODE(1)) u_rr4 (
      .clk(clk), .rst(rst), .sel(sel[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
      .in_data(dat[2]), .in_last(lst[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_data(od[2]), .out_ch(och[2]), .out_last(ol[2]));

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int cfg_n(input int d);
      return (d == 1) ? 3 : 4;
   endfunction

   function automatic int cfg_mode(input int d);
      return (d == 2) ? 1 : 0;
   endfunction

   // Reference model state: what the output register should hold and arbitration context.
   bit       m_ov    [3];
   int       m_od    [3];
   int       m_och   [3];
   bit       m_ol    [3];
   int       m_ptr   [3];
   bit       m_lock  [3];
   int       m_lockch[3];
   logic [3:0] s_rdy [3];

   task automatic step();
      int  g  [3];
      bit  ld [3];
      int  n, c;
      logic [3:0] exp_r;
      #1;
      for (int d = 0; d < 3; d++) begin
         n     = cfg_n(d);
         ld[d] = !m_ov[d] || ordy[d];
         g[d]  = -1;
         if (!rst) begin
            if (LOCK && m_lock[d]) begin
               if (vld[d][m_lockch[d]]) g[d] = m_lockch[d];
            end else if (cfg_mode(d) == 0) begin
               if (int'(sel[d]) < n && vld[d][sel[d]]) g[d] = int'(sel[d]);
            end else begin
               for (int k = 0; k < n; k++) begin
                  c = (m_ptr[d] + k) % n;
                  if (g[d] < 0 && vld[d][c]) g[d] = c;
               end
            end
         end
         exp_r    = (ld[d] && g[d] >= 0) ? (4'b0001 << g[d]) : 4'b0000;
         s_rdy[d] = rdy[d];
         check($sformatf("in_ready[dut%0d]", d), 32'(rdy[d]), 32'(exp_r));
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         n = cfg_n(d);
         if (rst) begin
            m_ov[d] = 0; m_od[d] = 0; m_och[d] = 0; m_ol[d] = 0;
            m_ptr[d] = 0; m_lock[d] = 0; m_lockch[d] = 0;
         end else if (ld[d]) begin
            if (g[d] >= 0) begin
               m_ov[d]  = 1;
               m_od[d]  = int'(dat[d][g[d]*8 +: 8]);
               m_och[d] = g[d];
               m_ol[d]  = lst[d][g[d]];
               if (LOCK) begin
                  m_lock[d]   = !lst[d][g[d]];
                  m_lockch[d] = g[d];
               end
               if (!LOCK || lst[d][g[d]]) m_ptr[d] = (g[d] + 1) % n;
            end else begin
               m_ov[d] = 0;
            end
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("out_valid[dut%0d]", d), 32'(ov[d]),  32'(m_ov[d]));
         check($sformatf("out_data[dut%0d]", d),  32'(od[d]),  m_od[d]);
         check($sformatf("out_ch[dut%0d]", d),    32'(och[d]), m_och[d]);
         check($sformatf("out_last[dut%0d]", d),  32'(ol[d]),  32'(m_ol[d]));
      end
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         vld[d] = '0; dat[d] = '0; lst[d] = '0; sel[d] = '0; ordy[d] = 1'b1;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   int sent;

   initial begin
      idle_all();
      for (int d = 0; d < 3; d++) begin
         m_ov[d] = 0; m_od[d] = 0; m_och[d] = 0; m_ol[d] = 0;
         m_ptr[d] = 0; m_lock[d] = 0; m_lockch[d] = 0;
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Fixed select on channel 2, then reset clears the held beat.
      sel[0] = 2'd2; vld[0] = 4'b0100; dat[0][23:16] = 8'hA5; lst[0] = 4'b0100;
      step();
      check("fixed_rdy", 32'(s_rdy[0]), 32'h4);
      check("fixed_valid", 32'(ov[0]), 32'h1);
      check("fixed_data", 32'(od[0]), 32'hA5);
      check("fixed_ch", 32'(och[0]), 32'h2);
      pulse_reset();
      check("rst_rdy", 32'(s_rdy[0]), 32'h0);
      check("rst_valid", 32'(ov[0]), 32'h0);
      check("rst_data", 32'(od[0]), 32'h0);
      vld[0] = '0;

      // Out-of-range select on the 3-channel instance.
      sel[1] = 2'd3; vld[1] = 4'b0111; dat[1] = 32'h00_33_22_11;
      for (int i = 0; i < 4; i++) begin
         step();
         check("oor_rdy", 32'(s_rdy[1]), 32'h0);
         check("oor_valid", 32'(ov[1]), 32'h0);
      end
      vld[1] = '0;

      // Back-pressure: 0x11 held three cycles, then 0x22 follows without a bubble.
      sel[0] = 2'd1; vld[0] = 4'b0010; dat[0] = 32'h0000_1100; lst[0] = 4'b0000;
      step();
      check("bp_first", 32'(od[0]), 32'h11);
      ordy[0] = 1'b0; dat[0][15:8] = 8'h22;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_data", 32'(od[0]), 32'h11);
         check("bp_hold_rdy", 32'(s_rdy[0]), 32'h0);
      end
      ordy[0] = 1'b1;
      step();
      check("bp_release_rdy", 32'(s_rdy[0]), 32'h2);
      check("bp_next_valid", 32'(ov[0]), 32'h1);
      check("bp_next_data", 32'(od[0]), 32'h22);
      vld[0] = '0;

      // Round-robin fairness and skip/wrap on the RR instance.
      pulse_reset();
      vld[2] = 4'b1111; dat[2] = 32'h33_22_11_00; lst[2] = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         step();
         check("rr_fair_ch", 32'(och[2]), 32'(i % 4));
      end
      vld[2] = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rr_skip_ch", 32'(och[2]), (i % 2 == 0) ? 32'h0 : 32'h3);
      end
      vld[2] = 4'b0000;
      step();
      step();
      check("rr_idle_valid", 32'(ov[2]), 32'h0);
      vld[2] = 4'b1001;
      step();
      check("rr_after_idle_ch", 32'(och[2]), 32'h0);
      vld[2] = '0;

      // Packet: ch0 sends three beats (last on the third) while ch1 stays valid.
      pulse_reset();
      sent = 0;
      dat[2] = 32'h0000_B1A0; lst[2] = 4'b0010; vld[2] = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         lst[2][0] = (sent == 2);
         vld[2][0] = (sent < 3);
         step();
         if (s_rdy[2][0]) sent++;
         check("pkt_ch", 32'(och[2]), (i == 3) ? 32'h1 : (LOCK ? 32'h0 : 32'(i % 2)));
      end

      // Random traffic on all three instances.
      pulse_reset();
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 3; d++) begin
            vld[d]  = 4'($urandom);
            dat[d]  = $urandom;
            lst[d]  = 4'($urandom);
            sel[d]  = 2'($urandom);
            ordy[d] = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-to-1 stream multiplexer with a valid/ready handshake and one registered output stage.
- Successor to the team's combinational 2:1 select mux. Adds channel-count and width generalisation, a selectable fixed or round-robin mode, and back-pressure.
- Sits between multiple producer streams and a single consumer. Also serves as the arbitration point for shared datapaths.

Parameters:
- N_CH, 2, number of input channels (min 2).
- WIDTH, 8, data width per channel in bits.
- MODE, 0, 0 = fixed select driven by `sel`; 1 = round-robin arbitration (`sel` ignored).
- SEL_W, $clog2(N_CH), derived localparam: width of the channel index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- sel  in  SEL_W  channel select; MODE 0 only.
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready; at most one bit set.
- in_data  in  N_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  N_CH  end-of-packet flag; used only with the optional feature, otherwise ignored.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  registered data.
- out_ch  out  SEL_W  index of the source channel of the held beat.
- out_last  out  1  registered copy of in_last of the granted beat.

Behaviour:
- Reset: on rst=1 at a clock edge:
  - out_valid=0, out_data=0, out_ch=0, out_last=0.
  - Round-robin pointer set to 0; lock cleared.
  - in_ready is combinational and is 0 while rst=1.
- load = ~out_valid | out_ready. The output register can accept a beat this cycle.
- Grant (combinational, one-hot or zero):
  - MODE 0: grant channel `sel` iff sel < N_CH and in_valid[sel]. sel >= N_CH gives no grant.
  - MODE 1: grant the first channel with in_valid set, searching from the pointer upward with wrap-around (pointer, pointer+1, …, N_CH-1, 0, …).
- in_ready[i] = load & grant[i]. Ready never depends on a channel's own in_valid beyond the grant logic; no other channel sees ready.
- Transfer on channel i when in_valid[i] & in_ready[i]. At the next edge:
  - out_data ← channel i data; out_ch ← i; out_last ← in_last[i]; out_valid ← 1.
- Latency: exactly 1 cycle from input transfer to out_valid. Full throughput: 1 beat per cycle when out_ready is held at 1.
- Output hold: if out_valid & ~out_ready, the output register holds unchanged and all in_ready are 0.
- Drain: if out_ready=1 and there is no grant, out_valid ← 0 at the next edge. out_data, out_ch and out_last keep their last values.
- Round-robin pointer: updates only on a transfer, to (granted index + 1) mod N_CH. A cycle with no transfer leaves it unchanged.
- Simultaneous events: a drain and a fresh load in the same cycle are a single register update with no bubble.
- sel change mid-stream: takes effect in the same cycle. Beats already transferred are unaffected.
- Reset mid-transfer: the beat held in the output register is discarded and no in_ready is asserted during the reset cycle.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- Defined: packet lock.
  - After a transfer with in_last=0, the grant is locked to that channel until a beat with in_last=1 transfers from it.
  - While locked, other channels and sel changes are ignored, and the round-robin pointer does not advance.
  - The pointer advances on the transfer of the last beat.
  - Lock is cleared by rst.
- Not defined: per-beat arbitration as described in Behaviour. in_last is passed through to out_last only and never affects grant.

Decomposition:
- Shared package stream_mux_pkg holds:
  - Mode constants MUX_MODE_FIXED=0 and MUX_MODE_RR=1.
  - The index-width function (clog2 wrapper).
- One sub-module, rr_arbiter: N_CH-wide request vector in, one-hot grant out, pointer register, advance-enable input.
  - Used only when MODE=1; a generate block selects it over the fixed-select path.

Test Plan:
- Reset and fixed select:
  - Stimulus: N_CH=4, WIDTH=8, MODE 0, sel=2, in_valid=4'b0100, data[2]=0xA5, out_ready=1.
  - Required response: in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
  - Then assert rst for one cycle; out_valid=0, out_data=0.
- Out-of-range select:
  - Stimulus: N_CH=3, sel=3, all in_valid=1.
  - Required response: in_ready=0 every cycle and out_valid stays 0.
- Back-pressure:
  - Stimulus: a beat of 0x11 is held with out_ready=0 for 3 cycles while channel 1 keeps valid high.
  - Required response: out_data stays 0x11 and in_ready=0 throughout. After out_ready rises, the next beat follows with no bubble.
- Round-robin fairness:
  - Stimulus: MODE 1, N_CH=4, all in_valid=1, out_ready=1 for 8 cycles.
  - Required response: out_ch sequence is 0,1,2,3,0,1,2,3.
- Round-robin skip and wrap:
  - Stimulus: MODE 1, in_valid=4'b1001.
  - Required response: out_ch sequence is 0,3,0,3. The pointer is unchanged across idle cycles.
- Packet lock (STREAM_MUX_LOCK_EN):
  - Stimulus: MODE 1, ch0 sends 3 beats with last on the 3rd; ch1 is valid throughout.
  - Required response: out_ch is 0,0,0,1.
  - Without the macro, the same stimulus gives 0,1,0,1.
